// File: rtl/unit_pkg.sv
// Shared state/type encodings and the spawn stat table for combat_unit.
package unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DEPLOY = 2'd1,
    ST_ALIVE  = 2'd2,
    ST_DYING  = 2'd3
  } unit_state_e;

  typedef enum logic [1:0] {
    UT_NONE = 2'd0,
    UT_1    = 2'd1,
    UT_2    = 2'd2,
    UT_3    = 2'd3
  } unit_type_e;

  typedef struct packed {
    logic [7:0] hp;
    logic [7:0] pwr;
    logic [2:0] cd;
  } unit_stats_t;

  localparam unit_stats_t STATS_NONE = '{hp: 8'd0,   pwr: 8'd0,   cd: 3'd0};
  localparam unit_stats_t STATS_T1   = '{hp: 8'd159, pwr: 8'd15,  cd: 3'd1};
  localparam unit_stats_t STATS_T2   = '{hp: 8'd123, pwr: 8'd16,  cd: 3'd0};
  localparam unit_stats_t STATS_T3   = '{hp: 8'd155, pwr: 8'd133, cd: 3'd3};

  function automatic unit_stats_t lookup_stats(input unit_type_e t);
    case (t)
      UT_1:    return STATS_T1;
      UT_2:    return STATS_T2;
      UT_3:    return STATS_T3;
      default: return STATS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/unit_cooldown.sv
// Attack cooldown counter: load wins over decrement, decrement stops at zero.
module unit_cooldown #(
  parameter int CD_W = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_i,
  input  logic [CD_W-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CD_W-1:0] count_q, count_d;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking so every register samples pre-edge values.
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/combat_unit.sv
// One lane combatant slot: spawn, march, attack on contact, take damage, die.
// Optional macro COMBAT_UNIT_DYING_EN adds a DYING hold-off before the slot can respawn.
module combat_unit
  import unit_pkg::*;
#(
  parameter int POS_W       = 9,
  parameter int HP_W        = 8,
  parameter int DMG_W       = 8,
  parameter int SIDE        = 1,
  parameter int SPAWN_POS   = 400,
  parameter int CD_W        = 3,
  parameter int DEATH_TICKS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             move_scen,
  input  logic             damage_scen,
  input  logic             can_spawn,
  input  logic [1:0]       spawn_type,
  input  logic [DMG_W-1:0] damage_in,
  input  logic [POS_W-1:0] unit_front,
  output logic             spawn_ack,
  output logic [POS_W-1:0] position,
  output logic [DMG_W-1:0] damage_out,
  output logic [1:0]       unit_type,
  output logic             dead
);

  localparam logic [POS_W-1:0] SPAWN_AT = (SIDE != 0) ? '0 : POS_W'(SPAWN_POS);
  localparam int CMP_W = (DMG_W > HP_W) ? DMG_W : HP_W;

  unit_state_e      state_q, state_d;
  unit_type_e       type_q, type_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [DMG_W-1:0] pwr_q, pwr_d;
  logic [CD_W-1:0]  cdmax_q, cdmax_d;
  logic [DMG_W-1:0] dmg_q, dmg_d;
  logic             ack_q, ack_d;

  logic             cd_load, cd_dec, cd_zero;
  logic [CD_W-1:0]  cd_load_val;
  logic             advance, kill;
  unit_stats_t      stats;

`ifdef COMBAT_UNIT_DYING_EN
  localparam int DT_W = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
  logic [DT_W-1:0] dcnt_q, dcnt_d;
`endif

  unit_cooldown #(.CD_W(CD_W)) u_cooldown (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cd_load),
    .load_val_i (cd_load_val),
    .dec_i      (cd_dec),
    .zero_o     (cd_zero)
  );

  assign stats = lookup_stats(type_q);
  // A killing hit is one that would take health to zero or below.
  assign kill  = damage_scen && (CMP_W'(damage_in) >= CMP_W'(hp_q));

  always_comb begin
    if (SIDE != 0) advance = (unit_front > pos_q) && (pos_q != '1);
    else           advance = (unit_front < pos_q) && (pos_q != '0);
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    pos_d       = pos_q;
    hp_d        = hp_q;
    pwr_d       = pwr_q;
    cdmax_d     = cdmax_q;
    dmg_d       = '0;
    ack_d       = 1'b0;
    cd_load     = 1'b0;
    cd_load_val = '0;
    cd_dec      = 1'b0;
`ifdef COMBAT_UNIT_DYING_EN
    dcnt_d      = dcnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (can_spawn && (spawn_type != 2'd0)) begin
          state_d = ST_DEPLOY;
          ack_d   = 1'b1;
          type_d  = unit_type_e'(spawn_type);
        end
      end
      ST_DEPLOY: begin
        hp_d    = HP_W'(stats.hp);
        pwr_d   = DMG_W'(stats.pwr);
        cdmax_d = CD_W'(stats.cd);
        cd_load = 1'b1;
        pos_d   = SPAWN_AT;
        state_d = ST_ALIVE;
      end
      ST_ALIVE: begin
        if (kill) begin
`ifdef COMBAT_UNIT_DYING_EN
          state_d = ST_DYING;
          dcnt_d  = '0;
`else
          state_d = ST_IDLE;
`endif
        end else begin
          // Surviving hit: damage_in < hp_q, so the subtraction cannot wrap.
          if (damage_scen) hp_d = hp_q - HP_W'(damage_in);
          if (move_scen) begin
            if (advance) begin
              pos_d = (SIDE != 0) ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            end else if (cd_zero) begin
              dmg_d       = pwr_q;
              cd_load     = 1'b1;
              cd_load_val = cdmax_q;
            end else begin
              cd_dec = 1'b1;
            end
          end
        end
      end
`ifdef COMBAT_UNIT_DYING_EN
      ST_DYING: begin
        if (move_scen) begin
          if (dcnt_q == DT_W'(DEATH_TICKS - 1)) state_d = ST_IDLE;
          else                                  dcnt_d  = dcnt_q + DT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      type_q  <= UT_NONE;
      pos_q   <= SPAWN_AT;
      hp_q    <= '0;
      pwr_q   <= '0;
      cdmax_q <= '0;
      dmg_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pos_q   <= pos_d;
      hp_q    <= hp_d;
      pwr_q   <= pwr_d;
      cdmax_q <= cdmax_d;
      dmg_q   <= dmg_d;
      ack_q   <= ack_d;
    end
  end

`ifdef COMBAT_UNIT_DYING_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) dcnt_q <= '0;
    else       dcnt_q <= dcnt_d;
  end
`endif

  assign spawn_ack  = ack_q;
  assign position   = pos_q;
  assign damage_out = dmg_q;
  assign unit_type  = (state_q == ST_ALIVE) ? type_q : UT_NONE;
  assign dead       = (state_q != ST_ALIVE);

endmodule
